// File: rtl/x25519_operand_loader.sv
// Collects the 64-byte scalar/u stream, decodes both operands and sequences the ladder through reset, run and done.
// k/x_p update one cycle after the last byte; in_ready drops from the last accepted byte until ladder_done.
module x25519_operand_loader #(
  parameter int RST_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic [254:0] k,
  output logic [254:0] x_p,
  output logic         ladder_rst,
  input  logic         ladder_done,
  output logic         busy,
  output logic         op_done
);

  typedef enum logic [2:0] {LOAD_K, LOAD_U, REDUCE, KICK, RUN} state_t;

  state_t       state;
  logic [5:0]   byte_cnt;
  logic [255:0] k_raw;
  logic [255:0] u_raw;
  logic [15:0]  kick_cnt;
  logic [255:0] u_plus;
  logic         accept;
  logic         unused_bits;

  // A carry into bit 255 means um >= p, and the low 255 bits are then um - p.
  assign u_plus      = {1'b0, u_raw[254:0]} + 256'd19;
  assign accept      = in_valid && in_ready;
  assign unused_bits = ^{k_raw[255:254], k_raw[2:0], u_raw[255]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD_K;
      byte_cnt   <= 6'd0;
      k_raw      <= '0;
      u_raw      <= '0;
      k          <= '0;
      x_p        <= '0;
      kick_cnt   <= '0;
      in_ready   <= 1'b0;
      ladder_rst <= 1'b1;
      busy       <= 1'b0;
      op_done    <= 1'b0;
    end else begin
      op_done <= 1'b0;
      case (state)
        LOAD_K, LOAD_U: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (byte_cnt[5])
              u_raw[{byte_cnt[4:0], 3'b000} +: 8] <= in_data;
            else
              k_raw[{byte_cnt[4:0], 3'b000} +: 8] <= in_data;
            byte_cnt <= byte_cnt + 6'd1;
            if (byte_cnt == 6'd31)
              state <= LOAD_U;
            if (byte_cnt == 6'd63) begin
              state    <= REDUCE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        REDUCE: begin
          k        <= {1'b1, k_raw[253:3], 3'b000};
          x_p      <= u_plus[255] ? u_plus[254:0] : u_raw[254:0];
          kick_cnt <= 16'(RST_CYCLES - 1);
          state    <= KICK;
        end
        KICK: begin
          if (kick_cnt == 16'd0) begin
            state      <= RUN;
            ladder_rst <= 1'b0;
          end else begin
            kick_cnt <= kick_cnt - 16'd1;
          end
        end
        RUN: begin
          if (ladder_done) begin
            op_done    <= 1'b1;
            ladder_rst <= 1'b1;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
            state      <= LOAD_K;
          end
        end
        default: state <= LOAD_K;
      endcase
    end
  end

endmodule

// File: tb/tb_x25519_operand_loader.sv
// Directed bench for x25519_operand_loader: table of operand pairs plus reset, gap and stale-done sequences.
module tb_x25519_operand_loader;
  localparam int RST_CYCLES = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [254:0] k;
  logic [254:0] x_p;
  logic         ladder_rst;
  logic         ladder_done;
  logic         busy;
  logic         op_done;

  int n_chk = 0;
  int n_fail = 0;

  x25519_operand_loader #(.RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .k(k), .x_p(x_p), .ladder_rst(ladder_rst), .ladder_done(ladder_done),
    .busy(busy), .op_done(op_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] sc;
    logic [255:0] u;
    logic [255:0] ek;
    logic [255:0] ex;
    int           run_cyc;
  } vec_t;

  vec_t vecs[5];

  localparam logic [255:0] RFC_SC  = 256'hc49a44ba_44226a50_185afcc1_0a4c1462_dd5e4682_4b15163b_9d7c52f0_6be346a5;
  localparam logic [255:0] RFC_K   = 256'h449a44ba_44226a50_185afcc1_0a4c1462_dd5e4682_4b15163b_9d7c52f0_6be346a0;
  localparam logic [255:0] P_VAL   = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [255:0] PM1     = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffec;
  localparam logic [255:0] ALL_FF  = 256'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff;
  localparam logic [255:0] P_HI    = 256'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [255:0] K_ZERO  = 256'h40000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000;
  localparam logic [255:0] K_FF    = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffff8;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves in_valid high with a filler byte so any premature consumption shows up.
  task automatic send_bytes(input logic [255:0] sc, input logic [255:0] u, input int nbytes, input bit gaps);
    logic ok;
    int   waited;
    for (int j = 0; j < nbytes; j++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = (j < 32) ? sc[8*j +: 8] : u[8*(j-32) +: 8];
      waited   = 0;
      do begin
        ok = in_ready;
        @(posedge clk); #1;
        waited++;
      end while (!ok && waited < 500);
      if (!ok) chk("accept_timeout", 256'(j), 256'(64));
    end
    in_data = 8'h55;
  endtask

  task automatic run_op(input vec_t v, input bit gaps, input string tag);
    int   cyc;
    logic stable;
    send_bytes(v.sc, v.u, 64, gaps);
    chk({tag, "_busy"}, 256'(busy), 256'(1));
    chk({tag, "_rdy_reduce"}, 256'(in_ready), 256'(0));
    @(posedge clk); #1;
    chk({tag, "_k"}, {1'b0, k}, v.ek);
    chk({tag, "_x_p"}, {1'b0, x_p}, v.ex);
    chk({tag, "_rst_kick"}, 256'(ladder_rst), 256'(1));
    cyc    = 0;
    stable = 1'b1;
    while (ladder_rst && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (in_ready) stable = 1'b0;
    end
    chk({tag, "_kick_len"}, 256'(cyc), 256'(RST_CYCLES));
    for (int i = 0; i < v.run_cyc; i++) begin
      @(posedge clk); #1;
      if (ladder_rst || in_ready || op_done || !busy || {1'b0, k} !== v.ek || {1'b0, x_p} !== v.ex)
        stable = 1'b0;
    end
    chk({tag, "_run_stable"}, 256'(stable), 256'(1));
    ladder_done = 1'b1;
    @(posedge clk); #1;
    ladder_done = 1'b0;
    in_valid    = 1'b0;
    chk({tag, "_op_done"}, 256'(op_done), 256'(1));
    chk({tag, "_rst_after"}, 256'(ladder_rst), 256'(1));
    chk({tag, "_rdy_after"}, 256'(in_ready), 256'(1));
    chk({tag, "_busy_after"}, 256'(busy), 256'(0));
    @(posedge clk); #1;
    chk({tag, "_op_done_pulse"}, 256'(op_done), 256'(0));
  endtask

  initial begin
    logic stale_ok;
    int   w;
    vecs[0] = '{RFC_SC, 256'd9, RFC_K, 256'd9, 1000};
    vecs[1] = '{256'd0, ALL_FF, K_ZERO, 256'd18, 5};
    vecs[2] = '{ALL_FF, P_VAL, K_FF, 256'd0, 5};
    vecs[3] = '{RFC_SC, PM1, RFC_K, PM1, 5};
    vecs[4] = '{256'd0, P_HI, K_ZERO, 256'd0, 5};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ladder_done = 1'b0;
    #12;
    chk("reset_in_ready", 256'(in_ready), 256'(0));
    chk("reset_ladder_rst", 256'(ladder_rst), 256'(1));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_op_done", 256'(op_done), 256'(0));
    chk("reset_k", {1'b0, k}, 256'd0);
    chk("reset_x_p", {1'b0, x_p}, 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 256'(in_ready), 256'(1));

    for (int i = 0; i < 5; i++)
      run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Stale done while loading must be ignored.
    ladder_done = 1'b1;
    stale_ok    = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (op_done || !ladder_rst || busy || !in_ready) stale_ok = 1'b0;
    end
    ladder_done = 1'b0;
    chk("stale_done_ignored", 256'(stale_ok), 256'(1));

    run_op(vecs[0], 1'b1, "gaps");

    // Reset after 40 bytes discards the partial load.
    send_bytes(ALL_FF, ALL_FF, 40, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midload_rst_ready", 256'(in_ready), 256'(0));
    chk("midload_rst_ladder", 256'(ladder_rst), 256'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(vecs[1], 1'b0, "after_rst");

    // Reset during RUN releases nothing and raises ladder_rst at once.
    send_bytes(vecs[3].sc, vecs[3].u, 64, 1'b0);
    in_valid = 1'b0;
    w = 0;
    while (ladder_rst && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("run_reached", 256'(ladder_rst), 256'(0));
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("run_rst_ladder", 256'(ladder_rst), 256'(1));
    chk("run_rst_busy", 256'(busy), 256'(0));
    chk("run_rst_k", {1'b0, k}, 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(vecs[2], 1'b0, "after_run_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
